// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: registered operands, one-cycle ADD/SUB/ADC/SBC/
// AND/OR/XOR, WIDTH-cycle shift-add multiply, registered result and flags,
// low result half driven onto the tri-state internal ALU bus.
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             Start,
  input  logic             EnableAlu,
  output logic [WIDTH-1:0] IB_Alu,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  // Iteration counter width is derived from WIDTH, never set by the user.
  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ADC = 3'b010,
    OP_SBC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  state_t               state_q;
  op_t                  op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_hi_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNTW-1:0]      cnt_q;
  logic                 carry_q;
  logic                 zero_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     b_eff;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic                 arith_ovf;
  logic                 is_logic;
  logic [WIDTH-1:0]     exec_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 mul_last;

  // Single-cycle datapath: (WIDTH+1)-bit adder plus bitwise logic ops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    b_eff    = b_q;
    cin      = 1'b0;
    exec_res = '0;
    is_logic = 1'b0;
    case (op_q)
      OP_SUB: begin
        b_eff = ~b_q;
        cin   = 1'b1;
      end
      OP_ADC: cin = carry_q;
      OP_SBC: begin
        b_eff = ~b_q;
        cin   = carry_q;
      end
      default: ;
    endcase
    sum       = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    arith_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    case (op_q)
      OP_AND: begin
        exec_res = a_q & b_q;
        is_logic = 1'b1;
      end
      OP_OR: begin
        exec_res = a_q | b_q;
        is_logic = 1'b1;
      end
      OP_XOR: begin
        exec_res = a_q ^ b_q;
        is_logic = 1'b1;
      end
      default: exec_res = sum[WIDTH-1:0];
    endcase
  end

  // One shift-add step: conditionally add A into the upper half, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_last = (cnt_q == CNTW'(WIDTH - 1));
  end

  // Control FSM with registered result, flags, Busy and Done.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op_t'(Op);
            acc_q   <= {{WIDTH{1'b0}}, B};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (op_t'(Op) == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q    <= exec_res;
          result_hi_q <= '0;
          zero_q      <= (exec_res == '0);
          neg_q       <= exec_res[WIDTH-1];
          if (is_logic) begin
            ovf_q <= 1'b0;
          end else begin
            carry_q <= sum[WIDTH];
            ovf_q   <= arith_ovf;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_MUL: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNTW'(1);
          if (mul_last) begin
            result_q    <= acc_next[WIDTH-1:0];
            result_hi_q <= acc_next[2*WIDTH-1:WIDTH];
            carry_q     <= (acc_next[2*WIDTH-1:WIDTH] != '0);
            zero_q      <= (acc_next == '0);
            neg_q       <= acc_next[WIDTH-1];
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The bus is released whenever the ALU is not selected as its driver.
  assign IB_Alu   = EnableAlu ? result_q : {WIDTH{1'bz}};
  assign ResultHi = result_hi_q;
  assign Carry    = carry_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;
  assign Overflow = ovf_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit: a WIDTH=4 and a WIDTH=8 instance on a
// shared clock and reset. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_seq_arith_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] op4 = '0;
  logic       start4 = 1'b0, en4 = 1'b1;
  wire  [3:0] ib4;
  logic [3:0] hi4;
  logic       c4, z4, n4, v4, busy4, done4;

  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] op8 = '0;
  logic       start8 = 1'b0, en8 = 1'b1;
  wire  [7:0] ib8;
  logic [7:0] hi8;
  logic       c8, z8, n8, v8, busy8, done8;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt;

  // A released bus floats high through these pull-ups.
  pullup (ib4[0]);
  pullup (ib4[1]);
  pullup (ib4[2]);
  pullup (ib4[3]);

  seq_arith_unit #(.WIDTH(4)) dut4 (
    .Clock(clk), .Reset(rst), .A(a4), .B(b4), .Op(op4), .Start(start4),
    .EnableAlu(en4), .IB_Alu(ib4), .ResultHi(hi4), .Carry(c4), .Zero(z4),
    .Negative(n4), .Overflow(v4), .Busy(busy4), .Done(done4)
  );

  seq_arith_unit #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset(rst), .A(a8), .B(b8), .Op(op8), .Start(start8),
    .EnableAlu(en8), .IB_Alu(ib8), .ResultHi(hi8), .Carry(c8), .Zero(z8),
    .Negative(n8), .Overflow(v8), .Busy(busy8), .Done(done8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op with Start for one edge; returns in the first Busy cycle.
  task automatic issue4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    op4 = op; a4 = a; b4 = b; start4 = 1'b1;
    step();
    start4 = 1'b0;
  endtask

  task automatic flags4(input string tag, input logic c, input logic z, input logic n, input logic v);
    check({tag, "_flags"}, {12'd0, c4, z4, n4, v4}, {12'd0, c, z, n, v});
  endtask

  // Non-MUL op: Busy in N+1, Done plus result in N+2.
  task automatic run4(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    issue4(op, a, b);
    check({tag, "_busy"}, {15'd0, busy4, done4}, 16'h0002);
    step();
    check({tag, "_done"}, {15'd0, busy4, done4}, 16'h0001);
  endtask

  initial begin
    step();
    step();
    check("rst_ctrl", {14'd0, busy4, done4}, 16'h0000);
    check("rst_bus", {12'd0, ib4}, 16'h0000);
    check("rst_hi", {12'd0, hi4}, 16'h0000);
    flags4("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // ADD 7+9 wraps to 0 with carry out
    run4("add79", OP_ADD, 4'h7, 4'h9);
    check("add79_bus", {12'd0, ib4}, 16'h0000);
    flags4("add79", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("add79_done_pulse", {15'd0, done4}, 16'h0000);

    // ADC uses the carry left by the previous ADD: 2+3+1
    run4("adc23", OP_ADC, 4'h2, 4'h3);
    check("adc23_bus", {12'd0, ib4}, 16'h0006);
    flags4("adc23", 1'b0, 1'b0, 1'b0, 1'b0);

    // SUB with borrow, then SUB with signed overflow
    run4("sub35", OP_SUB, 4'h3, 4'h5);
    check("sub35_bus", {12'd0, ib4}, 16'h000E);
    flags4("sub35", 1'b0, 1'b0, 1'b1, 1'b0);
    run4("sub81", OP_SUB, 4'h8, 4'h1);
    check("sub81_bus", {12'd0, ib4}, 16'h0007);
    flags4("sub81", 1'b1, 1'b0, 1'b0, 1'b1);

    // MUL F*F over 4 cycles; a Start pulse in the second Busy cycle must be ignored
    done_cnt = 0;
    issue4(OP_MUL, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("mulff_busy", {15'd0, busy4}, 16'h0001);
      done_cnt += int'(done4);
      if (i == 1) begin
        op4 = OP_ADD; a4 = 4'h1; b4 = 4'h1; start4 = 1'b1;
      end
      step();
      start4 = 1'b0;
    end
    check("mulff_done", {15'd0, busy4, done4}, 16'h0001);
    check("mulff_hi", {12'd0, hi4}, 16'h000E);
    check("mulff_bus", {12'd0, ib4}, 16'h0001);
    flags4("mulff", 1'b1, 1'b0, 1'b0, 1'b0);
    done_cnt += int'(done4);
    for (int i = 0; i < 4; i++) begin
      step();
      done_cnt += int'(done4);
      check("mulff_idle_busy", {15'd0, busy4}, 16'h0000);
    end
    check("mulff_done_count", 16'(done_cnt), 16'd1);

    // XOR after a carry-setting ADD keeps Carry, then bus release and restore
    run4("add79b", OP_ADD, 4'h7, 4'h9);
    run4("xoraa", OP_XOR, 4'hA, 4'hA);
    check("xoraa_bus", {12'd0, ib4}, 16'h0000);
    check("xoraa_hi", {12'd0, hi4}, 16'h0000);
    flags4("xoraa", 1'b1, 1'b1, 1'b0, 1'b0);
    en4 = 1'b0;
    #1;
    check("bus_released", {12'd0, ib4}, 16'h000F);
    en4 = 1'b1;
    #1;
    check("bus_restored", {12'd0, ib4}, 16'h0000);

    // Nonzero state first, then reset in cycle 2 of a MUL
    run4("add56", OP_ADD, 4'h5, 4'h6);
    check("add56_bus", {12'd0, ib4}, 16'h000B);
    flags4("add56", 1'b0, 1'b0, 1'b1, 1'b1);
    issue4(OP_MUL, 4'h3, 4'h5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mulrst_ctrl", {14'd0, busy4, done4}, 16'h0000);
    check("mulrst_bus", {12'd0, ib4}, 16'h0000);
    check("mulrst_hi", {12'd0, hi4}, 16'h0000);
    flags4("mulrst", 1'b0, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      done_cnt += int'(done4) + int'(busy4);
    end
    check("mulrst_no_done", 16'(done_cnt), 16'd0);
    run4("add11", OP_ADD, 4'h1, 4'h1);
    check("add11_bus", {12'd0, ib4}, 16'h0002);

    // WIDTH=8: MUL 200*3 = 0x258, then back-to-back ADD issued in the Done cycle
    op8 = OP_MUL; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("mul8_busy", {14'd0, busy8, done8}, 16'h0002);
      step();
    end
    check("mul8_done", {14'd0, busy8, done8}, 16'h0001);
    check("mul8_hi", {8'd0, hi8}, 16'h0002);
    check("mul8_bus", {8'd0, ib8}, 16'h0058);
    check("mul8_flags", {12'd0, c8, z8, n8, v8}, 16'h0008);
    op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("b2b_busy", {14'd0, busy8, done8}, 16'h0002);
    step();
    check("b2b_done", {14'd0, busy8, done8}, 16'h0001);
    check("b2b_bus", {8'd0, ib8}, 16'h0080);
    check("b2b_hi", {8'd0, hi8}, 16'h0000);
    check("b2b_flags", {12'd0, c8, z8, n8, v8}, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised, clocked successor to the 4-bit combinational add/sub unit that drives the internal ALU bus.
- Registers its operands on a Start handshake and executes ADD, SUB, ADC, SBC, AND, OR and XOR in one execute cycle.
- Executes an unsigned shift-add multiply over WIDTH cycles.
- Holds the result and status flags in registers; drives the low result half onto the tri-state internal bus IB_Alu under EnableAlu.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).
- CNTW, clog2(WIDTH)+1, multiply iteration counter width (derived; not overridden).

Ports:
- Clock  in  1  single system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A, sampled on an accepted Start.
- B  in  WIDTH  operand B, sampled on an accepted Start.
- Op  in  3  opcode, sampled on an accepted Start: 000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 MUL.
- Start  in  1  request; accepted only in IDLE.
- EnableAlu  in  1  bus drive enable.
- IB_Alu  out  WIDTH  tri-state bus output: result register when EnableAlu=1, else all Z.
- ResultHi  out  WIDTH  high half of MUL product; 0 after any non-MUL op.
- Carry  out  1  carry flag register.
- Zero  out  1  zero flag register.
- Negative  out  1  negative flag register (MSB of low result).
- Overflow  out  1  signed overflow flag register.
- Busy  out  1  high while in EXEC or MUL.
- Done  out  1  one-cycle pulse: result and flags updated.

Behaviour:
- Reset (synchronous, priority over everything): state IDLE, result register 0, ResultHi 0, all flags 0, Busy 0, Done 0, counter 0. IB_Alu follows EnableAlu (0 or Z).
- Reset asserted mid-operation abandons the operation; no Done is produced.
- States: IDLE, EXEC, MUL.
  - IDLE & Start: latch A, B, Op. Next state is MUL if Op=111, else EXEC.
  - EXEC (1 cycle): compute, write result and flags, return to IDLE.
  - MUL (WIDTH cycles): LSB-first shift-add into a 2*WIDTH accumulator. On the last iteration write low half to the result register, high half to ResultHi, update flags, return to IDLE.
- Latency, with Start sampled at edge N:
  - non-MUL: Busy=1 during cycle N+1; Done=1 and new result visible in cycle N+2.
  - MUL: Busy=1 for WIDTH cycles; Done=1 in cycle N+WIDTH+1.
- Done lasts exactly one cycle, with Busy=0. A Start in the Done cycle is accepted (back-to-back operations). Start while Busy=1 is ignored; latched operands and Op are unaffected.
- Arithmetic is (WIDTH+1)-bit internally:
  - ADD = A+B
  - SUB = A+~B+1
  - ADC = A+B+Carry
  - SBC = A+~B+Carry
  - Carry = bit WIDTH of the sum. For subtract, Carry=1 means no borrow.
  - Overflow = signed overflow: operand sign bits (B inverted for SUB/SBC) equal and result sign differs.
- Logic ops: Carry keeps its previous value; Overflow=0.
- MUL: Carry = (ResultHi != 0); Overflow=0; Zero = full 2*WIDTH product == 0.
- All other ops: Zero = (result == 0); ResultHi=0.
- Negative = result[WIDTH-1] for all ops.
- ADC/SBC use the Carry value registered before the op starts.
- The result register holds its value until the next Done or Reset. EnableAlu may toggle at any time, including while Busy; the bus then shows the previous result.

Test Plan:
- WIDTH=4, ADD A=7 B=9 -> Done in cycle N+2; result 0x0, Carry=1, Zero=1, Overflow=0, Negative=0. Then ADC A=2 B=3 -> result 0x6, Carry=0.
- WIDTH=4, SUB A=3 B=5 -> result 0xE, Carry=0, Negative=1, Overflow=0. SUB A=0x8 B=0x1 -> result 0x7, Carry=1, Overflow=1.
- WIDTH=4, MUL A=0xF B=0xF -> Busy high 4 cycles, Done in cycle N+5; ResultHi=0xE, IB_Alu=0x1, Carry=1, Zero=0. A Start pulse during Busy is ignored: exactly one Done.
- WIDTH=4, XOR A=0xA B=0xA after a carry-setting ADD -> result 0, Zero=1, Carry still 1, Overflow=0. With EnableAlu=0, IB_Alu=ZZZZ; restoring EnableAlu=1 shows 0x0 immediately.
- Reset asserted in cycle 2 of a WIDTH=4 MUL -> next cycle Busy=0, result, ResultHi and flags 0, no Done. A new ADD 1+1 afterwards -> 0x2 at N+2.
- WIDTH=8, MUL 200*3 -> ResultHi=0x02, IB_Alu=0x58, Done in cycle N+9. Back-to-back ADD 0x7F+0x01 issued in the Done cycle -> result 0x80, Overflow=1, Negative=1.
